// File: rtl/mips32_pkg.sv
// mips32_pkg: shared encodings for the MIPS32 back end.
//   ALUOp codes from the main decoder, R-type funct codes, the internal
//   ALU_Control encoding and an R-format view of the instruction word.
package mips32_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ADDI  = 2'b11;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_MFHI, ALU_MFLO, ALU_MULT, ALU_MULTU, ALU_NONE
  } alu_ctrl_e;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_r_t;

endpackage

// File: rtl/mips32_ex_alu.sv
// mips32_ex_alu: combinational EX stage - ALU control decode, ALU and multiplier.
//   i_alu_op   ALUOp from ID/EX          i_funct / i_shamt  instruction fields
//   i_a, i_b   operands (B already muxed) i_hi, i_lo        current HI/LO
//   o_result   ALU result                o_zero             result == 0
//   o_mul_en   mult/multu in EX          o_product          64-bit {HI,LO} to load
module mips32_ex_alu
  import mips32_pkg::*;
(
  input  logic [1:0]  i_alu_op,
  input  logic [5:0]  i_funct,
  input  logic [4:0]  i_shamt,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [31:0] o_result,
  output logic        o_zero,
  output logic        o_mul_en,
  output logic [63:0] o_product
);

  alu_ctrl_e   w_ctrl;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;

  always_comb begin
    w_ctrl = ALU_NONE;
    case (i_alu_op)
      ALUOP_ADD, ALUOP_ADDI: w_ctrl = ALU_ADD;
      ALUOP_SUB:             w_ctrl = ALU_SUB;
      default: begin
        case (i_funct)
          FN_ADD, FN_ADDU: w_ctrl = ALU_ADD;
          FN_SUB, FN_SUBU: w_ctrl = ALU_SUB;
          FN_AND:          w_ctrl = ALU_AND;
          FN_OR:           w_ctrl = ALU_OR;
          FN_XOR:          w_ctrl = ALU_XOR;
          FN_NOR:          w_ctrl = ALU_NOR;
          FN_SLT:          w_ctrl = ALU_SLT;
          FN_SLTU:         w_ctrl = ALU_SLTU;
          FN_SLL:          w_ctrl = ALU_SLL;
          FN_SRL:          w_ctrl = ALU_SRL;
          FN_SRA:          w_ctrl = ALU_SRA;
          FN_MFHI:         w_ctrl = ALU_MFHI;
          FN_MFLO:         w_ctrl = ALU_MFLO;
          FN_MULT:         w_ctrl = ALU_MULT;
          FN_MULTU:        w_ctrl = ALU_MULTU;
          default:         w_ctrl = ALU_NONE;
        endcase
      end
    endcase
  end

  assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  always_comb begin
    o_result = '0;
    case (w_ctrl)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_NOR:  o_result = ~(i_a | i_b);
      ALU_SLT:  o_result = {31'd0, $signed(i_a) < $signed(i_b)};
      ALU_SLTU: o_result = {31'd0, i_a < i_b};
      ALU_SLL:  o_result = i_b << i_shamt;
      ALU_SRL:  o_result = i_b >> i_shamt;
      ALU_SRA:  o_result = $signed(i_b) >>> i_shamt;
      ALU_MFHI: o_result = i_hi;
      ALU_MFLO: o_result = i_lo;
      default:  o_result = '0;
    endcase
  end

  assign o_zero    = (o_result == '0);
  assign o_mul_en  = (w_ctrl == ALU_MULT) || (w_ctrl == ALU_MULTU);
  assign o_product = (w_ctrl == ALU_MULTU) ? w_prod_u : w_prod_s;

endmodule

// File: rtl/mips32_backend.sv
// mips32_backend: EX, MEM and WB stages of the 5-stage MIPS32 pipeline.
//   Inputs : Clk, Rst_n (async, active low), ID/EX control and data
//            (*_EX signals).
//   Outputs: branch redirect PCSrc_MEM / Branch_Dest_MEM and register-file
//            write port RegWrite_WB / Write_Register_WB / Write_Data_WB.
//   Owns HI/LO, the EX/MEM and MEM/WB registers and a synchronous data RAM.
module mips32_backend
  import mips32_pkg::*;
#(
  parameter int    DMEM_ADDR_W = 8,
  parameter string DMEM_INIT   = ""
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        RegWrite_EX,
  input  logic        MemtoReg_EX,
  input  logic        Branch_EX,
  input  logic        MemRead_EX,
  input  logic        MemWrite_EX,
  input  logic        RegDst_EX,
  input  logic        ALUSrc_EX,
  input  logic [1:0]  ALUOp_EX,
  input  logic [31:0] PC_Plus_4_EX,
  input  logic [31:0] Read_Data_1_EX,
  input  logic [31:0] Read_Data_2_EX,
  input  logic [31:0] Sign_Extend_Instruction_EX,
  input  logic [31:0] Instruction_EX,
  output logic        PCSrc_MEM,
  output logic [31:0] Branch_Dest_MEM,
  output logic        RegWrite_WB,
  output logic [4:0]  Write_Register_WB,
  output logic [31:0] Write_Data_WB
);

  instr_r_t    w_instr;
  logic [31:0] w_alu_b;
  logic [31:0] w_alu_result;
  logic        w_zero;
  logic        w_mul_en;
  logic [63:0] w_product;
  logic [4:0]  w_write_reg;
  logic [31:0] w_branch_dest;
  logic [DMEM_ADDR_W-1:0] w_dmem_addr;
  logic        w_unused_bits;

  logic [31:0] r_hi, r_lo;
  logic        r_regwrite_mem, r_memtoreg_mem, r_branch_mem, r_zero_mem;
  logic [31:0] r_bdest_mem, r_alu_mem;
  logic [4:0]  r_wreg_mem;
  logic        r_regwrite_wb, r_memtoreg_wb;
  logic [31:0] r_memq_wb, r_alu_wb;
  logic [4:0]  r_wreg_wb;
  logic [31:0] r_dmem_q;
  logic [31:0] r_dmem [2**DMEM_ADDR_W];

  assign w_instr       = instr_r_t'(Instruction_EX);
  assign w_unused_bits = &{1'b0, w_instr.op, w_instr.rs, w_instr.funct};

  assign w_alu_b       = ALUSrc_EX ? Sign_Extend_Instruction_EX : Read_Data_2_EX;
  assign w_write_reg   = RegDst_EX ? w_instr.rd : w_instr.rt;
  assign w_branch_dest = PC_Plus_4_EX + {Sign_Extend_Instruction_EX[29:0], 2'b00};
  assign w_dmem_addr   = w_alu_result[DMEM_ADDR_W+1:2];

  mips32_ex_alu u_alu (
    .i_alu_op  (ALUOp_EX),
    .i_funct   (Sign_Extend_Instruction_EX[5:0]),
    .i_shamt   (w_instr.shamt),
    .i_a       (Read_Data_1_EX),
    .i_b       (w_alu_b),
    .i_hi      (r_hi),
    .i_lo      (r_lo),
    .o_result  (w_alu_result),
    .o_zero    (w_zero),
    .o_mul_en  (w_mul_en),
    .o_product (w_product)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_hi           <= '0;
      r_lo           <= '0;
      r_regwrite_mem <= 1'b0;
      r_memtoreg_mem <= 1'b0;
      r_branch_mem   <= 1'b0;
      r_zero_mem     <= 1'b0;
      r_bdest_mem    <= '0;
      r_alu_mem      <= '0;
      r_wreg_mem     <= '0;
      r_regwrite_wb  <= 1'b0;
      r_memtoreg_wb  <= 1'b0;
      r_memq_wb      <= '0;
      r_alu_wb       <= '0;
      r_wreg_wb      <= '0;
    end else begin
      if (w_mul_en) begin
        r_hi <= w_product[63:32];
        r_lo <= w_product[31:0];
      end
      r_regwrite_mem <= RegWrite_EX & ~w_mul_en;
      r_memtoreg_mem <= MemtoReg_EX;
      r_branch_mem   <= Branch_EX;
      r_zero_mem     <= w_zero;
      r_bdest_mem    <= w_branch_dest;
      r_alu_mem      <= w_alu_result;
      r_wreg_mem     <= w_write_reg;
      r_regwrite_wb  <= r_regwrite_mem;
      r_memtoreg_wb  <= r_memtoreg_mem;
      r_memq_wb      <= r_dmem_q;
      r_alu_wb       <= r_alu_mem;
      r_wreg_wb      <= r_wreg_mem;
    end
  end

  // Stores are blocked while reset is held so that a discarded instruction
  // cannot leave a side effect in memory.
  always_ff @(posedge Clk) begin
    if (MemWrite_EX && Rst_n) r_dmem[w_dmem_addr] <= Read_Data_2_EX;
    if (MemRead_EX)           r_dmem_q <= r_dmem[w_dmem_addr];
  end

  assign PCSrc_MEM         = r_branch_mem & r_zero_mem;
  assign Branch_Dest_MEM   = r_bdest_mem;
  assign RegWrite_WB       = r_regwrite_wb & (r_wreg_wb != '0);
  assign Write_Register_WB = r_wreg_wb;
  assign Write_Data_WB     = r_memtoreg_wb ? r_memq_wb : r_alu_wb;

endmodule

// File: tb/tb_mips32_backend.sv
// tb_mips32_backend: randomized self-checking bench for mips32_backend with an
// instruction-level reference model (ISA semantics + fixed stage latency).
module tb_mips32_backend;

  logic        Clk, Rst_n;
  logic        RegWrite_EX, MemtoReg_EX, Branch_EX, MemRead_EX, MemWrite_EX;
  logic        RegDst_EX, ALUSrc_EX;
  logic [1:0]  ALUOp_EX;
  logic [31:0] PC_Plus_4_EX, Read_Data_1_EX, Read_Data_2_EX;
  logic [31:0] Sign_Extend_Instruction_EX, Instruction_EX;
  logic        PCSrc_MEM, RegWrite_WB;
  logic [31:0] Branch_Dest_MEM, Write_Data_WB;
  logic [4:0]  Write_Register_WB;

  mips32_backend #(.DMEM_ADDR_W(8), .DMEM_INIT("")) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX), .Branch_EX(Branch_EX),
    .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX), .RegDst_EX(RegDst_EX),
    .ALUSrc_EX(ALUSrc_EX), .ALUOp_EX(ALUOp_EX), .PC_Plus_4_EX(PC_Plus_4_EX),
    .Read_Data_1_EX(Read_Data_1_EX), .Read_Data_2_EX(Read_Data_2_EX),
    .Sign_Extend_Instruction_EX(Sign_Extend_Instruction_EX),
    .Instruction_EX(Instruction_EX), .PCSrc_MEM(PCSrc_MEM),
    .Branch_Dest_MEM(Branch_Dest_MEM), .RegWrite_WB(RegWrite_WB),
    .Write_Register_WB(Write_Register_WB), .Write_Data_WB(Write_Data_WB)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic rw, mtr, br, mr, mw, rdst, asrc;
    logic [1:0]  op;
    logic [31:0] pc, rs, rt, ins;
  } op_t;

  typedef struct {
    logic        pcsrc;
    logic [31:0] bdest;
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        chk;
  } exp_t;

  localparam int K_ADDI = 0, K_LW = 1, K_SW = 2, K_BEQ = 3;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] m_hi, m_lo;
  logic [31:0] m_mem [256];
  exp_t        e_ex, e_mem, e_wb;
  exp_t        e_zero;
  op_t         nop;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic op_t mk_r(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt,
                               input logic [4:0] rd, input logic [4:0] sh);
    op_t o = nop;
    o.rw = 1'b1; o.rdst = 1'b1; o.op = 2'b10;
    o.rs = rs; o.rt = rt; o.pc = $urandom & 32'hFFFF_FFFC;
    o.ins = {6'h00, 5'd1, 5'd2, rd, sh, fn};
    return o;
  endfunction

  function automatic op_t mk_i(input int kind, input logic [31:0] rs, input logic [31:0] rt,
                               input logic [4:0] rtreg, input logic [15:0] imm);
    op_t o = nop;
    o.rs = rs; o.rt = rt; o.pc = $urandom & 32'hFFFF_FFFC;
    o.ins = {6'h23, 5'd3, rtreg, imm};
    case (kind)
      K_ADDI:  begin o.rw = 1'b1; o.asrc = 1'b1; o.op = 2'b11; end
      K_LW:    begin o.rw = 1'b1; o.mtr = 1'b1; o.mr = 1'b1; o.asrc = 1'b1; end
      K_SW:    begin o.mw = 1'b1; o.asrc = 1'b1; end
      default: begin o.br = 1'b1; o.op = 2'b01; end
    endcase
    return o;
  endfunction

  // Executes one instruction against the architectural state in program order.
  function automatic exp_t ref_exec(input op_t o);
    exp_t e;
    logic [31:0] imm, b, res, ld;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [7:0]  idx;
    logic        mul;
    longint      sa, sb;
    logic [63:0] p;
    imm = {{16{o.ins[15]}}, o.ins[15:0]};
    b   = o.asrc ? imm : o.rt;
    fn  = o.ins[5:0];
    sh  = o.ins[10:6];
    res = 32'd0; ld = 32'd0; mul = 1'b0;
    case (o.op)
      2'b01: res = o.rs - b;
      2'b10: begin
        case (fn)
          6'h20, 6'h21: res = o.rs + b;
          6'h22, 6'h23: res = o.rs - b;
          6'h24: res = o.rs & b;
          6'h25: res = o.rs | b;
          6'h26: res = o.rs ^ b;
          6'h27: res = ~(o.rs | b);
          6'h2A: res = ($signed(o.rs) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2B: res = (o.rs < b) ? 32'd1 : 32'd0;
          6'h00: res = b << sh;
          6'h02: res = b >> sh;
          6'h03: res = $signed(b) >>> sh;
          6'h10: res = m_hi;
          6'h12: res = m_lo;
          6'h18: begin
            sa = $signed(o.rs); sb = $signed(b);
            p = 64'(sa * sb);
            m_hi = p[63:32]; m_lo = p[31:0]; mul = 1'b1;
          end
          6'h19: begin
            p = {32'd0, o.rs} * {32'd0, b};
            m_hi = p[63:32]; m_lo = p[31:0]; mul = 1'b1;
          end
          default: res = 32'd0;
        endcase
      end
      default: res = o.rs + b;
    endcase
    idx = res[9:2];
    if (o.mr) ld = m_mem[idx];
    if (o.mw) m_mem[idx] = o.rt;
    e.wr    = o.rdst ? o.ins[15:11] : o.ins[20:16];
    e.rw    = o.rw && !mul && (e.wr != 5'd0);
    e.wd    = o.mtr ? ld : res;
    e.chk   = e.rw;
    e.pcsrc = o.br && (res == 32'd0);
    e.bdest = o.pc + (imm << 2);
    return e;
  endfunction

  task automatic drive(input op_t o);
    RegWrite_EX = o.rw;  MemtoReg_EX = o.mtr; Branch_EX = o.br;
    MemRead_EX  = o.mr;  MemWrite_EX = o.mw;  RegDst_EX = o.rdst;
    ALUSrc_EX   = o.asrc; ALUOp_EX  = o.op;   PC_Plus_4_EX = o.pc;
    Read_Data_1_EX = o.rs; Read_Data_2_EX = o.rt; Instruction_EX = o.ins;
    Sign_Extend_Instruction_EX = {{16{o.ins[15]}}, o.ins[15:0]};
  endtask

  function automatic op_t rnd_garbage();
    op_t o;
    o.rw = 1'($urandom); o.mtr = 1'($urandom); o.br = 1'($urandom);
    o.mr = 1'($urandom); o.mw = 1'($urandom); o.rdst = 1'($urandom);
    o.asrc = 1'($urandom); o.op = 2'($urandom);
    o.pc = $urandom; o.rs = $urandom; o.rt = $urandom; o.ins = $urandom;
    return o;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // One cycle: the edge advances the model's latency line, the new EX
  // instruction is applied, and MEM/WB outputs are checked mid-cycle.
  task automatic step(input op_t o);
    @(posedge Clk);
    e_wb  = e_mem;
    e_mem = e_ex;
    #1;
    drive(o);
    e_ex = ref_exec(o);
    @(negedge Clk);
    chk("pcsrc", 64'(PCSrc_MEM), 64'(e_mem.pcsrc));
    chk("bdest", 64'(Branch_Dest_MEM), 64'(e_mem.bdest));
    chk("regwrite", 64'(RegWrite_WB), 64'(e_wb.rw));
    chk("wreg", 64'(Write_Register_WB), 64'(e_wb.wr));
    if (e_wb.chk) chk("wdata", 64'(Write_Data_WB), 64'(e_wb.wd));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pcsrc"}, 64'(PCSrc_MEM), 64'd0);
    chk({tag, "_bdest"}, 64'(Branch_Dest_MEM), 64'd0);
    chk({tag, "_rw"}, 64'(RegWrite_WB), 64'd0);
    chk({tag, "_wreg"}, 64'(Write_Register_WB), 64'd0);
    chk({tag, "_wdata"}, 64'(Write_Data_WB), 64'd0);
  endtask

  task automatic model_reset();
    m_hi = 32'd0; m_lo = 32'd0;
    e_ex = e_zero; e_mem = e_zero; e_wb = e_zero;
  endtask

  task automatic do_reset();
    step(nop);
    Rst_n = 1'b0;
    #1;
    chk_zero("rst_async");
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk); #1;
      drive(rnd_garbage());
      @(negedge Clk);
      chk_zero("rst_hold");
    end
    drive(nop);
    Rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run1(input op_t o, input string tag, input logic [31:0] exp);
    step(o); step(nop); step(nop);
    chk(tag, 64'(Write_Data_WB), 64'(exp));
  endtask

  op_t o;
  logic [31:0] r;

  initial begin
    nop = '{rw: 1'b0, mtr: 1'b0, br: 1'b0, mr: 1'b0, mw: 1'b0, rdst: 1'b0, asrc: 1'b0,
            op: 2'b00, pc: 32'd0, rs: 32'd0, rt: 32'd0, ins: 32'd0};
    e_zero = '{pcsrc: 1'b0, bdest: 32'd0, rw: 1'b0, wr: 5'd0, wd: 32'd0, chk: 1'b0};
    Rst_n = 1'b0;
    drive(rnd_garbage());
    #23;
    chk_zero("por");
    @(negedge Clk);
    drive(nop);
    Rst_n = 1'b1;
    model_reset();

    // R-type add and the rd=0 write suppression
    run1(mk_r(6'h20, 32'd5, 32'd7, 5'd3, 5'd0), "add_5_7", 32'd12);
    chk("add_rw", 64'(RegWrite_WB), 64'd1);
    chk("add_wreg", 64'(Write_Register_WB), 64'd3);
    step(mk_r(6'h20, 32'd5, 32'd7, 5'd0, 5'd0)); step(nop); step(nop);
    chk("add_rd0_rw", 64'(RegWrite_WB), 64'd0);

    // store then load of the same word, then an aliased address
    step(mk_i(K_SW, 32'h40, 32'hDEADBEEF, 5'd1, 16'h0000));
    run1(mk_i(K_LW, 32'h40, 32'd0, 5'd8, 16'h0000), "lw_0x40", 32'hDEADBEEF);
    run1(mk_i(K_LW, 32'h440, 32'd0, 5'd9, 16'h0000), "lw_0x440", 32'hDEADBEEF);

    // beq taken / not taken
    o = mk_i(K_BEQ, 32'd9, 32'd9, 5'd9, 16'hFFFC); o.pc = 32'h100;
    step(o); step(nop);
    chk("beq_taken", 64'(PCSrc_MEM), 64'd1);
    chk("beq_dest", 64'(Branch_Dest_MEM), 64'hF0);
    o.rt = 32'd10;
    step(o); step(nop);
    chk("beq_not_taken", 64'(PCSrc_MEM), 64'd0);

    // mult / multu followed immediately by mfhi and mflo
    step(mk_r(6'h18, 32'hFFFF_FFFF, 32'd2, 5'd0, 5'd0));
    step(mk_r(6'h10, 32'd0, 32'd0, 5'd4, 5'd0));
    step(mk_r(6'h12, 32'd0, 32'd0, 5'd5, 5'd0));
    step(nop); chk("mult_hi", 64'(Write_Data_WB), 64'hFFFF_FFFF);
    step(nop); chk("mult_lo", 64'(Write_Data_WB), 64'hFFFF_FFFE);
    step(mk_r(6'h19, 32'hFFFF_FFFF, 32'd2, 5'd0, 5'd0));
    step(mk_r(6'h10, 32'd0, 32'd0, 5'd4, 5'd0));
    step(mk_r(6'h12, 32'd0, 32'd0, 5'd5, 5'd0));
    step(nop); chk("multu_hi", 64'(Write_Data_WB), 64'h1);
    step(nop); chk("multu_lo", 64'(Write_Data_WB), 64'hFFFF_FFFE);

    // wrap and signed/unsigned compare
    run1(mk_r(6'h20, 32'h7FFF_FFFF, 32'd1, 5'd6, 5'd0), "add_ovf", 32'h8000_0000);
    run1(mk_r(6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd7, 5'd0), "slt", 32'd1);
    run1(mk_r(6'h2B, 32'hFFFF_FFFF, 32'd1, 5'd7, 5'd0), "sltu", 32'd0);

    // in-flight instruction discarded by a mid-stream reset
    step(mk_r(6'h20, 32'd1, 32'd1, 5'd6, 5'd0));
    do_reset();
    step(nop); step(nop);
    chk("rst_flush_rw", 64'(RegWrite_WB), 64'd0);

    // give every data word a known value
    for (int i = 0; i < 256; i++) begin
      r = $urandom;
      step(mk_i(K_SW, {r[31:10], i[7:0], r[1:0]}, $urandom, 5'($urandom), 16'h0000));
    end

    // randomized instruction stream
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) do_reset();
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          logic [5:0] fn;
          case ($urandom_range(0, 16))
            0: fn = 6'h20;  1: fn = 6'h21;  2: fn = 6'h22;  3: fn = 6'h23;
            4: fn = 6'h24;  5: fn = 6'h25;  6: fn = 6'h26;  7: fn = 6'h27;
            8: fn = 6'h2A;  9: fn = 6'h2B; 10: fn = 6'h00; 11: fn = 6'h02;
            12: fn = 6'h03; 13: fn = 6'h10; 14: fn = 6'h12;
            15: fn = ($urandom_range(0, 1) == 0) ? 6'h18 : 6'h19;
            default: fn = 6'($urandom);
          endcase
          o = mk_r(fn, rnd_val(), rnd_val(), 5'($urandom), 5'($urandom));
        end
        4: o = mk_i(K_ADDI, rnd_val(), $urandom, 5'($urandom), 16'($urandom));
        5: o = mk_i(K_LW, $urandom, $urandom, 5'($urandom), 16'($urandom));
        6: o = mk_i(K_SW, $urandom, rnd_val(), 5'($urandom), 16'($urandom));
        7: begin
          r = rnd_val();
          o = mk_i(K_BEQ, r, ($urandom_range(0, 1) == 0) ? r : rnd_val(),
                   5'($urandom), 16'($urandom));
        end
        default: o = nop;
      endcase
      step(o);
    end
    step(nop); step(nop);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
